// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache
// controller between the core MEM stage and the shared data memory.
// Read hits are answered combinationally. Misses run a 4-word line fill and
// stores run a single-word write-through over a req/ready memory handshake.
//
// Optional feature macro: DCACHE_STATS_EN (load hit/miss counters).
//
// Ports:
//   CLK, RSTn             clock, synchronous active-low reset
//   cpu_req/we/addr/wdata MEM-stage access (held stable while cpu_stall=1)
//   cpu_rdata             load data (combinational)
//   cpu_stall             core must hold its state (combinational)
//   mem_req/we/addr/wdata registered memory request
//   mem_rdata, mem_ready  memory response
//   hit_cnt, miss_cnt     load hit / miss statistics (0 without the macro)
module dcache_ctrl #(
   parameter int unsigned NUM_LINES = 8,
   parameter int unsigned ADDR_W    = 12
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic [15:0]       hit_cnt,
   output logic [15:0]       miss_cnt
);

   localparam int unsigned IDX_W = $clog2(NUM_LINES);
   localparam int unsigned TAG_W = ADDR_W - 4 - IDX_W;
   localparam int unsigned WORDS = NUM_LINES * 4;

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE} state_t;

   state_t                  state_q;
   logic [NUM_LINES-1:0]    valid_q;
   logic [TAG_W-1:0]        tag_q [NUM_LINES];
   logic [31:0]             data_q [WORDS];
   logic [1:0]              cnt_q;
   logic                    mem_req_q;
   logic                    mem_we_q;
   logic [ADDR_W-1:0]       mem_addr_q;
   logic [31:0]             mem_wdata_q;

   // CPU-side address decode and hit
   logic [1:0]              cpu_off;
   logic [IDX_W-1:0]        cpu_idx;
   logic [TAG_W-1:0]        cpu_tag;
   logic                    cpu_hit;
   logic                    load_hit;
   logic                    load_miss;
   logic                    unused_addr_lsb;

   assign cpu_off   = cpu_addr[3:2];
   assign cpu_idx   = cpu_addr[4 +: IDX_W];
   assign cpu_tag   = cpu_addr[ADDR_W-1 -: TAG_W];
   assign cpu_hit   = valid_q[cpu_idx] & (tag_q[cpu_idx] == cpu_tag);
   assign load_hit  = (state_q == S_IDLE) & cpu_req & ~cpu_we & cpu_hit;
   assign load_miss = (state_q == S_IDLE) & cpu_req & ~cpu_we & ~cpu_hit;
   assign unused_addr_lsb = ^cpu_addr[1:0];

   // Memory-side decode uses the registered request address, so an in-flight
   // transaction finishes correctly even if the core drops cpu_req.
   logic [1:0]              mem_off;
   logic [IDX_W-1:0]        mem_idx;
   logic [TAG_W-1:0]        mem_tag;
   logic                    mem_hit;
   logic                    fill_we;
   logic                    fill_last;
   logic                    wr_done;

   assign mem_off   = mem_addr_q[3:2];
   assign mem_idx   = mem_addr_q[4 +: IDX_W];
   assign mem_tag   = mem_addr_q[ADDR_W-1 -: TAG_W];
   assign mem_hit   = valid_q[mem_idx] & (tag_q[mem_idx] == mem_tag);
   assign fill_we   = (state_q == S_FILL) & mem_ready;
   assign fill_last = fill_we & (cnt_q == 2'd3);
   assign wr_done   = (state_q == S_WRITE) & mem_ready;

   assign cpu_rdata = data_q[{cpu_idx, cpu_off}];
   assign cpu_stall = cpu_req & ~load_hit & ~wr_done;

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

   // Controller FSM with registered memory-request outputs
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state_q     <= S_IDLE;
         valid_q     <= '0;
         cnt_q       <= 2'd0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cpu_req & cpu_we) begin
                  state_q     <= S_WRITE;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= {cpu_addr[ADDR_W-1:2], 2'b00};
                  mem_wdata_q <= cpu_wdata;
               end else if (load_miss) begin
                  state_q    <= S_FILL;
                  cnt_q      <= 2'd0;
                  mem_req_q  <= 1'b1;
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= {cpu_addr[ADDR_W-1:4], 4'b0000};
               end
            end
            S_FILL: begin
               if (mem_ready) begin
                  cnt_q           <= cnt_q + 2'd1;
                  mem_addr_q[3:2] <= cnt_q + 2'd1;
                  // valid only after the last word lands
                  if (cnt_q == 2'd3) begin
                     valid_q[mem_idx] <= 1'b1;
                     mem_req_q        <= 1'b0;
                     state_q          <= S_IDLE;
                  end
               end
            end
            S_WRITE: begin
               if (mem_ready) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  state_q   <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Tag and data arrays, not reset
   always_ff @(posedge CLK) begin
      if (fill_we) begin
         data_q[{mem_idx, cnt_q}] <= mem_rdata;
      end
      if (wr_done & mem_hit) begin
         data_q[{mem_idx, mem_off}] <= mem_wdata_q;
      end
      if (fill_last) begin
         tag_q[mem_idx] <= mem_tag;
      end
   end

`ifdef DCACHE_STATS_EN
   logic        replay_q;
   logic [15:0] hit_cnt_q;
   logic [15:0] miss_cnt_q;

   // Saturating load statistics; the post-fill replay hit is not counted
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         replay_q   <= 1'b0;
         hit_cnt_q  <= 16'd0;
         miss_cnt_q <= 16'd0;
      end else begin
         replay_q <= fill_last;
         if (load_hit & ~replay_q & (hit_cnt_q != 16'hFFFF)) begin
            hit_cnt_q <= hit_cnt_q + 16'd1;
         end
         if (load_miss & (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_q <= miss_cnt_q + 16'd1;
         end
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`else
   assign hit_cnt  = 16'd0;
   assign miss_cnt = 16'd0;
`endif

endmodule
